// File: rtl/clock_divider_pkg.sv
// Package: clock_divider_pkg
// Shared defaults and width helpers for the multi-channel clock divider.
//   DEFAULT_DIV_W : default divisor / counter width in bits
//   DEFAULT_N_CH  : default number of divider channels
//   clog2()       : ceiling log2 used to size the channel-select port
//   ch_width()    : channel-select width, never narrower than one bit
package clock_divider_pkg;

  localparam int DEFAULT_DIV_W = 16;
  localparam int DEFAULT_N_CH  = 4;

  // Ceiling log2; clog2(1) is 0, which ch_width() widens to one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// Module: clock_divider_channel
// One programmable divider channel: shadow/active divisor pair, period counter,
// registered square wave and terminal-count tick.
// Ports:
//   CLK_IN   in   1      clock, all logic on its rising edge
//   RST_N    in   1      asynchronous active-low reset
//   WR_EN    in   1      write strobe already decoded for this channel
//   WR_DIV   in   DIV_W  new divisor for the shadow register
//   SYNC     in   1      restart the period and adopt the shadow divisor
//   CLK_OUT  out  1      divided clock, low for ceil(D/2) cycles then high
//   TICK     out  1      one-cycle pulse on the last count of each period
//   PENDING  out  1      shadow divisor not yet adopted by the counter
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_W       = DEFAULT_DIV_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [DIV_W-1:0] WR_DIV,
  input  logic             SYNC,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             PENDING
);

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0] shadow_q, active_q, cnt_q;
  logic [DIV_W-1:0] shadow_d, active_d, cnt_d;
  logic [DIV_W-1:0] last_q, last_d, high_start;
  logic             clk_out_d, tick_d, pending_d;

  // Next-state and output decode. Outputs are derived from the next counter
  // value and next divisor so they land in the same cycle as the counter.
  // The divisor only changes at a period boundary (wrap, stopped channel or
  // SYNC), which is what keeps the output free of runt or stretched phases.
  always_comb begin
    shadow_d = WR_EN ? WR_DIV : shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    last_q   = active_q - ONE;

    if (SYNC) begin
      // A write in the same cycle as SYNC is adopted immediately.
      cnt_d    = '0;
      active_d = shadow_d;
    end else if (active_q == '0) begin
      // Stopped: pick up whatever divisor is queued and start from zero.
      cnt_d    = '0;
      active_d = shadow_q;
    end else if (cnt_q == last_q) begin
      cnt_d    = '0;
      active_d = shadow_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    last_d     = active_d - ONE;
    // The high phase starts at D - floor(D/2), so odd divisors are low longer.
    high_start = active_d - (active_d >> 1);
    tick_d     = !SYNC && (active_d != '0) && (cnt_d == last_d);
    clk_out_d  = !SYNC && (active_d != '0) && (cnt_d >= high_start);
    pending_d  = (shadow_d != active_d);
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      shadow_q <= RESET_DIV;
      active_q <= RESET_DIV;
      cnt_q    <= '0;
      CLK_OUT  <= 1'b0;
      TICK     <= 1'b0;
      PENDING  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      CLK_OUT  <= clk_out_d;
      TICK     <= tick_d;
      PENDING  <= pending_d;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Module: clock_divider_multi
// N-channel programmable integer clock divider. The processor writes a divisor
// per channel; each channel produces a divided clock and a tick enable.
// Ports:
//   CLK_IN   in   1      single clock, all logic on its rising edge
//   RST_N    in   1      asynchronous active-low reset
//   WR_EN    in   1      divisor write strobe
//   WR_CH    in   CH_W   target channel; indices >= N_CH are ignored
//   WR_DIV   in   DIV_W  new divisor for the target channel
//   SYNC     in   1      restart all channels in phase
//   CLK_OUT  out  N_CH   divided clock per channel
//   TICK     out  N_CH   terminal-count pulse per channel
//   PENDING  out  N_CH   divisor update queued per channel
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter  int N_CH        = DEFAULT_N_CH,
  parameter  int DIV_W       = DEFAULT_DIV_W,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = ch_width(N_CH)
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [CH_W-1:0]  WR_CH,
  input  logic [DIV_W-1:0] WR_DIV,
  input  logic             SYNC,
  output logic [N_CH-1:0]  CLK_OUT,
  output logic [N_CH-1:0]  TICK,
  output logic [N_CH-1:0]  PENDING
);

  // Each channel only matches its own index, so out-of-range channel numbers
  // never hit any instance and are dropped without extra range logic.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = WR_EN && (WR_CH == CH_W'(i));

    clock_divider_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .CLK_IN  (CLK_IN),
      .RST_N   (RST_N),
      .WR_EN   (wr_hit),
      .WR_DIV  (WR_DIV),
      .SYNC    (SYNC),
      .CLK_OUT (CLK_OUT[i]),
      .TICK    (TICK[i]),
      .PENDING (PENDING[i])
    );
  end

endmodule
